vr_packet_arbiter: RTL



---
 rtl/vr_packet_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vr_packet_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_SRC valid-ready packet streams
// into one stream, holding the grant from first beat until the last beat handshakes.
module vr_packet_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int IDX_W     = $clog2(NUM_SRC),
  parameter int CNT_W     = $clog2(MAX_BEATS) + 1
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      en,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_out_last,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_active,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      err_overlong
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_OVERLONG = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_SRC - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic             lock_en;
  logic             out_hs;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // The output mux always follows grant_idx, so source 0 is visible out of reset.
  assign data_out       = src_data[int'(grant_idx_q)*DATA_W +: DATA_W];
  assign data_out_last  = src_last[grant_idx_q];
  assign lock_en        = en && (state_q == LOCKED);
  assign data_out_valid = lock_en && src_valid[grant_idx_q];
  assign out_hs         = data_out_valid && data_out_ready;

  assign grant_idx    = grant_idx_q;
  assign grant_active = (state_q == LOCKED);
  assign beat_cnt     = beat_cnt_q;
  assign err_overlong = err_q;

  always_comb begin
    src_ready = '0;
    if (lock_en) begin
      src_ready[grant_idx_q] = data_out_ready;
    end
  end

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      cand_idx = IDX_W'(cand);
      if (!win_found && src_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_idx_d = win_idx;
            beat_cnt_d  = '0;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (out_hs) begin
            if (beat_cnt_q != CNT_MAX) begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (!data_out_last && (beat_cnt_q == CNT_OVERLONG)) begin
              err_d = 1'b1;
            end
            if (data_out_last) begin
              state_d  = IDLE;
              rr_ptr_d = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (sync_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
